// File: rtl/mul_arb_pkg.sv
// rtl/mul_arb_pkg.sv - shared widths and result entry type for the multiplier issue arbiter
package mul_arb_pkg;

  localparam int OPND_W = 32;
  localparam int PROD_W = 64;
  localparam int ID_W   = 1;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [PROD_W-1:0] product;
  } result_t;

endpackage

// File: rtl/mul_result_fifo.sv
// rtl/mul_result_fifo.sv - synchronous result FIFO with wrap-bit pointers
module mul_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra MSB distinguishes full from empty when the index bits match
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mul_issue_arbiter.sv
// rtl/mul_issue_arbiter.sv - round-robin credit-based issue of two requesters onto one pipelined multiplier
module mul_issue_arbiter
  import mul_arb_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OPND_W-1:0] req0_a,
  input  logic [OPND_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OPND_W-1:0] req1_a,
  input  logic [OPND_W-1:0] req1_b,
  output logic [OPND_W-1:0] mul_in1,
  output logic [OPND_W-1:0] mul_in2,
  input  logic [PROD_W-1:0] mul_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [PROD_W-1:0] rsp_data,
  output logic              busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CREDITS = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic            last_grant;
  logic            grant0;
  logic            grant1;
  logic            credit_ok;
  logic            issue;
  logic            issue_id;
  logic            pop;
  logic [CW-1:0]   outstanding;
  logic            pipe_valid [MUL_LATENCY];
  logic [ID_W-1:0] pipe_id    [MUL_LATENCY];
  result_t         push_entry;
  result_t         head_entry;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            unused_fifo;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant;
      grant1 = ~last_grant;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // Outstanding covers in-flight and buffered ops, so a full FIFO never sees a push
  assign credit_ok  = (outstanding < CREDITS);
  assign req0_ready = grant0 & credit_ok;
  assign req1_ready = grant1 & credit_ok;
  assign issue      = req0_ready | req1_ready;
  assign issue_id   = req1_ready;
  assign pop        = rsp_valid & rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_in1     <= '0;
      mul_in2     <= '0;
      last_grant  <= 1'b1;
      outstanding <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_id[i]    <= '0;
      end
    end else begin
      if (issue) begin
        mul_in1    <= issue_id ? req1_a : req0_a;
        mul_in2    <= issue_id ? req1_b : req0_b;
        last_grant <= issue_id;
      end
      // Multiplier cannot stall, so the tracking pipe shifts unconditionally
      for (int i = MUL_LATENCY - 1; i > 0; i--) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_id[i]    <= pipe_id[i-1];
      end
      pipe_valid[0] <= issue;
      pipe_id[0]    <= ID_W'(issue_id);
      if (issue && !pop)      outstanding <= outstanding + CNT_ONE;
      else if (!issue && pop) outstanding <= outstanding - CNT_ONE;
    end
  end

  assign push_entry.id      = pipe_id[MUL_LATENCY-1];
  assign push_entry.product = mul_out;

  mul_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(result_t))
  ) u_result_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (pipe_valid[MUL_LATENCY-1]),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign unused_fifo = ^{fifo_full, fifo_count};

  assign rsp_valid = ~fifo_empty;
  assign rsp_id    = fifo_empty ? '0 : head_entry.id;
  assign rsp_data  = fifo_empty ? '0 : head_entry.product;
  assign busy      = (outstanding != '0);

endmodule

// File: tb/tb_mul_issue_arbiter.sv
// tb/tb_mul_issue_arbiter.sv - directed self-checking bench for mul_issue_arbiter
module tb_mul_issue_arbiter;

  localparam int MUL_LATENCY = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] mul_in1, mul_in2;
  logic [63:0] mul_out;
  logic        rsp_valid, rsp_ready, busy;
  logic [0:0]  rsp_id;
  logic [63:0] rsp_data;

  int checks = 0;
  int errors = 0;
  int n;
  int acc;
  int i0, i1;
  logic g0;
  logic [64:0] got_q [$];

  logic [31:0] t0a [4] = '{32'd2, 32'd4, 32'd6, 32'd8};
  logic [31:0] t0b [4] = '{32'd3, 32'd5, 32'd7, 32'd9};
  logic [31:0] t1a [4] = '{32'd10, 32'd12, 32'd14, 32'd16};
  logic [31:0] t1b [4] = '{32'd11, 32'd13, 32'd15, 32'd17};
  logic        exp_id   [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [63:0] exp_data [8] = '{64'd6, 64'd110, 64'd20, 64'd156, 64'd42, 64'd210, 64'd72, 64'd272};

  logic [63:0] mstage [MUL_LATENCY-1] = '{default: '0};

  mul_issue_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .mul_in1    (mul_in1),
    .mul_in2    (mul_in2),
    .mul_out    (mul_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Pipelined multiplier model: product of operands loaded at edge t is sampled at edge t+MUL_LATENCY
  always @(posedge clk) begin
    mstage[0] <= 64'(mul_in1) * 64'(mul_in2);
    for (int i = 1; i < MUL_LATENCY - 1; i++) mstage[i] <= mstage[i-1];
  end
  assign mul_out = mstage[MUL_LATENCY-2];

  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) got_q.push_back({rsp_id, rsp_data});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_rsp(output int cnt);
    cnt = 0;
    while (!rsp_valid && cnt < 20) begin
      cyc();
      cnt++;
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 60) begin
      cyc();
      c++;
    end
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_req0_ready", 64'(req0_ready), 0);
    check("rst_req1_ready", 64'(req1_ready), 0);
    check("rst_mul_in1", 64'(mul_in1), 0);
    check("rst_mul_in2", 64'(mul_in2), 0);
    check("rst_rsp_valid", 64'(rsp_valid), 0);
    check("rst_rsp_id", 64'(rsp_id), 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_busy", 64'(busy), 0);
    reset = 1'b0;
    cyc();

    // Single op, latency and busy release
    rsp_ready = 1;
    req0_a = 3; req0_b = 5; req0_valid = 1;
    #1;
    check("t1_req0_ready", 64'(req0_ready), 1);
    check("t1_req1_ready", 64'(req1_ready), 0);
    cyc();
    req0_valid = 0;
    check("t1_mul_in1", 64'(mul_in1), 3);
    check("t1_mul_in2", 64'(mul_in2), 5);
    wait_rsp(n);
    check("t1_latency", 64'(n), MUL_LATENCY);
    check("t1_id", 64'(rsp_id), 0);
    check("t1_data", rsp_data, 64'd15);
    check("t1_busy_before_pop", 64'(busy), 1);
    cyc();
    check("t1_busy_after_pop", 64'(busy), 0);
    check("t1_rsp_valid_after_pop", 64'(rsp_valid), 0);

    // Max operands from req1
    req1_a = 32'hFFFF_FFFF; req1_b = 32'hFFFF_FFFF; req1_valid = 1;
    #1;
    check("t2_req1_ready", 64'(req1_ready), 1);
    cyc();
    req1_valid = 0;
    wait_rsp(n);
    check("t2_latency", 64'(n), MUL_LATENCY);
    check("t2_id", 64'(rsp_id), 1);
    check("t2_data", rsp_data, 64'hFFFF_FFFE_0000_0001);
    cyc();

    // Contention: grants alternate starting with req0
    got_q.delete();
    i0 = 0; i1 = 0;
    req0_a = t0a[0]; req0_b = t0b[0]; req1_a = t1a[0]; req1_b = t1b[0];
    req0_valid = 1; req1_valid = 1;
    #1;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
        cyc(); #1; n++;
      end
      check("t3_grant", 64'({req1_ready, req0_ready}), (k % 2 == 0) ? 64'd1 : 64'd2);
      g0 = req0_ready;
      cyc();
      if (g0) begin
        i0++;
        if (i0 < 4) begin req0_a = t0a[i0]; req0_b = t0b[i0]; end
        else req0_valid = 0;
      end else begin
        i1++;
        if (i1 < 4) begin req1_a = t1a[i1]; req1_b = t1b[i1]; end
        else req1_valid = 0;
      end
      #1;
    end
    req0_valid = 0; req1_valid = 0;
    wait_idle();
    check("t3_count", 64'(got_q.size()), 8);
    for (int k = 0; k < 8 && k < got_q.size(); k++) begin
      check("t3_id", 64'(got_q[k][64]), 64'(exp_id[k]));
      check("t3_data", got_q[k][63:0], exp_data[k]);
    end

    // Credit backpressure
    got_q.delete();
    rsp_ready = 0; acc = 0;
    req0_a = 7; req0_b = 1; req0_valid = 1;
    #1;
    for (int c = 0; c < 10; c++) begin
      g0 = req0_ready;
      cyc();
      if (g0) begin acc++; req0_b = req0_b + 1; end
      #1;
    end
    check("t4_accepts", 64'(acc), 4);
    check("t4_ready_blocked", 64'(req0_ready), 0);
    check("t4_busy", 64'(busy), 1);
    check("t4_rsp_valid", 64'(rsp_valid), 1);
    rsp_ready = 1;
    #1;
    check("t4_pop_no_same_cycle_credit", 64'(req0_ready), 0);
    cyc();
    rsp_ready = 0;
    #1;
    check("t4_credit_returned", 64'(req0_ready), 1);
    cyc();
    #1;
    check("t4_blocked_again", 64'(req0_ready), 0);
    req0_valid = 0;
    rsp_ready = 1;
    wait_idle();
    check("t4_count", 64'(got_q.size()), 5);
    for (int k = 0; k < 5 && k < got_q.size(); k++)
      check("t4_data", got_q[k][63:0], 64'(7 * (k + 1)));

    // Simultaneous push and pop with one entry buffered
    got_q.delete();
    rsp_ready = 0;
    req0_a = 9; req0_b = 9; req0_valid = 1;
    #1;
    cyc();
    req0_a = 11; req0_b = 11;
    #1;
    cyc();
    req0_valid = 0;
    wait_rsp(n);
    check("t5_latency", 64'(n), MUL_LATENCY - 1);
    check("t5_head_a", rsp_data, 64'd81);
    rsp_ready = 1;
    cyc();
    rsp_ready = 0;
    check("t5_valid_after_pushpop", 64'(rsp_valid), 1);
    check("t5_head_b", rsp_data, 64'd121);
    cyc();
    check("t5_head_b_held", rsp_data, 64'd121);
    check("t5_busy", 64'(busy), 1);
    rsp_ready = 1;
    cyc();
    check("t5_empty", 64'(rsp_valid), 0);
    check("t5_idle", 64'(busy), 0);
    check("t5_count", 64'(got_q.size()), 2);
    if (got_q.size() == 2) begin
      check("t5_order0", got_q[0][63:0], 64'd81);
      check("t5_order1", got_q[1][63:0], 64'd121);
    end

    // Reset with 3 in flight and 1 buffered
    rsp_ready = 0;
    req0_a = 100; req0_b = 3; req0_valid = 1;
    #1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      req0_b = req0_b + 1;
    end
    req0_valid = 0;
    cyc();
    check("t6_buffered", 64'(rsp_valid), 1);
    reset = 1;
    #1;
    check("t6_rst_rsp_valid", 64'(rsp_valid), 0);
    check("t6_rst_busy", 64'(busy), 0);
    cyc();
    cyc();
    reset = 0;
    got_q.delete();
    rsp_ready = 1;
    repeat (8) cyc();
    check("t6_no_stale", 64'(got_q.size()), 0);
    check("t6_idle", 64'(busy), 0);
    req1_a = 123456; req1_b = 1000; req1_valid = 1;
    #1;
    check("t6_req1_ready", 64'(req1_ready), 1);
    rsp_ready = 0;
    cyc();
    req1_valid = 0;
    wait_rsp(n);
    check("t6_latency", 64'(n), MUL_LATENCY);
    check("t6_id", 64'(rsp_id), 1);
    check("t6_data", rsp_data, 64'd123456000);
    rsp_ready = 1;
    cyc();
    check("t6_final_idle", 64'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
